// File: rtl/modulo_hamming_pkg.sv
// Shared definitions for the Hamming SECDED (8,4) link: codeword bit
// positions, the encoder function and the transmitter state encoding.
package modulo_hamming_pkg;

    // Codeword layout: cw[0..6] are Hamming positions 1..7, cw[7] is global parity.
    localparam int P1_POS = 0;
    localparam int P2_POS = 1;
    localparam int D0_POS = 2;
    localparam int P4_POS = 3;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int PG_POS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Global parity covers the seven Hamming bits, giving even parity over all eight.
    function automatic logic [7:0] hamming_encode(input logic [3:0] d);
        logic [7:0] cw;
        cw         = '0;
        cw[P1_POS] = d[0] ^ d[1] ^ d[3];
        cw[P2_POS] = d[0] ^ d[2] ^ d[3];
        cw[D0_POS] = d[0];
        cw[P4_POS] = d[1] ^ d[2] ^ d[3];
        cw[D1_POS] = d[1];
        cw[D2_POS] = d[2];
        cw[D3_POS] = d[3];
        cw[PG_POS] = ^cw[6:0];
        return cw;
    endfunction

endpackage

// File: rtl/modulo_codificador.sv
// Purely combinational (8,4) SECDED encoder.
module modulo_codificador
    import modulo_hamming_pkg::*;
(
    input  logic [3:0] data_in,
    output logic [7:0] codeword
);

    // Encoder is a thin wrapper so it can be exercised on its own.
    always_comb begin
        codeword = hamming_encode(data_in);
    end

endmodule

// File: rtl/modulo_transmisor_hamming.sv
// Hamming (8,4) transmitter: encodes a 4-bit word, applies an optional error
// mask and sends the codeword as a 10-bit UART frame (start, 8 bits LSB first, stop).
//
// Handshake: a word is taken on any rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; while it is low, in_valid, data_in and
// err_mask are not looked at, and the producer must keep offering the word.
module modulo_transmisor_hamming
    import modulo_hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic [7:0] err_mask,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] codeword_out,
    output tx_state_t  state_dbg
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    cw_q, cw_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [7:0]    enc_cw;
    logic          accept;
    logic          bit_end;

    modulo_codificador u_codificador (
        .data_in  (data_in),
        .codeword (enc_cw)
    );

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign accept       = in_valid && in_ready;
    assign bit_end      = (baud_q == BAUD_LAST);
    assign tx           = tx_q;
    assign done         = done_q;
    assign codeword_out = cw_q;
    assign state_dbg    = state_q;

    // All state and output registers; reset leaves the line idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cw_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cw_q    <= cw_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx_d is the line value for the bit that starts at this edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cw_d    = cw_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = enc_cw ^ err_mask;
                    cw_d    = enc_cw ^ err_mask;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        // Next bit is shift_q[1]: the shift lands on this same edge.
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_modulo_transmisor_hamming.sv
// Bench for the Hamming transmitter: scoreboard of expected codewords checked
// on every done pulse against codeword_out and the frame recovered from tx.
module tb_modulo_transmisor_hamming;
    import modulo_hamming_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic [7:0] err_mask;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] codeword_out;
    tx_state_t  state_dbg;

    logic [3:0] enc_d;
    logic [7:0] enc_cw;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_word = '0;

    modulo_transmisor_hamming #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .err_mask     (err_mask),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .codeword_out (codeword_out),
        .state_dbg    (state_dbg)
    );

    modulo_codificador u_enc (
        .data_in  (enc_d),
        .codeword (enc_cw)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Reference encoder built from Hamming position rules rather than the equations.
    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] c;
        logic       p;
        c    = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        for (int j = 0; j < 3; j++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (((pos >> j) & 1) == 1 && pos != (1 << j)) p = p ^ c[pos-1];
            end
            c[(1 << j) - 1] = p;
        end
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Receive-side model: {double, single, syndrome[2:0], corrected data[3:0]}.
    function automatic logic [8:0] rx_decode(input logic [7:0] r);
        logic [2:0] syn;
        logic [7:0] c;
        logic       par;
        logic       sgl;
        logic       dbl;
        syn = '0;
        for (int pos = 1; pos <= 7; pos++) begin
            if (r[pos-1]) syn = syn ^ 3'(pos);
        end
        par = ^r;
        sgl = (syn != 3'd0) && par;
        dbl = (syn != 3'd0) && !par;
        c   = r;
        if (sgl) c[syn - 3'd1] = ~c[syn - 3'd1];
        return {dbl, sgl, syn, c[6], c[5], c[4], c[2]};
    endfunction

    // scoreboard: each done pulse retires one expected codeword
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && done) begin
            done_cnt <= done_cnt + 1;
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_cw", codeword_out, e);
                check("sb_rx", rx_word, e);
            end
        end
    end

    // driver: offer one word, then follow the frame on tx to its done pulse
    task automatic run_frame(input logic [3:0] d, input logic [7:0] m, input bit hold,
                             output logic [7:0] rxw, output int acc_cyc);
        int         n;
        logic [9:0] f;
        logic [7:0] e;
        n   = 0;
        rxw = '0;
        acc_cyc = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_wait", 32'd0, 32'd1);
            return;
        end
        e        = ref_encode(d) ^ m;
        data_in  = d;
        err_mask = m;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        if (hold) data_in = ~d;
        else      in_valid = 1'b0;
        check("acc_cw", codeword_out, e);
        check("acc_tx", tx, 1'b0);
        check("acc_rdy_busy", {in_ready, busy}, 2'b01);
        repeat (2) @(negedge clk);
        f[0] = tx;
        for (int b = 1; b < 10; b++) begin
            repeat (CPB) @(negedge clk);
            f[b] = tx;
        end
        check("start_bit", f[0], 1'b0);
        check("stop_bit", f[9], 1'b1);
        rxw     = f[8:1];
        rx_word = f[8:1];
        n = 0;
        while (!done && n < 3 * CPB + 4) begin
            @(negedge clk);
            n++;
        end
        check("done_lat", cyc - acc_cyc, 10 * CPB);
        check("done_rdy_busy_tx", {in_ready, busy, tx}, 3'b101);
        if (!hold) begin
            @(negedge clk);
            check("done_1cyc", done, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rxw;
        int         acc1;
        int         acc2;
        int         d0;
        logic [8:0] dec;

        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        err_mask = '0;
        enc_d    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cw", codeword_out, 8'h00);
        check("rst_state", state_dbg, IDLE);

        // encoder alone, exhaustive plus fixed points
        for (int i = 0; i < 16; i++) begin
            enc_d = 4'(i);
            #1;
            check("enc", enc_cw, ref_encode(4'(i)));
        end
        enc_d = 4'hB; #1; check("enc_b", enc_cw, 8'h55);
        enc_d = 4'h0; #1; check("enc_0", enc_cw, 8'h00);
        enc_d = 4'hF; #1; check("enc_f", enc_cw, 8'hFF);
        @(negedge clk);

        // clean frames
        run_frame(4'hB, 8'h00, 1'b0, rxw, acc1);
        check("frame_b", rxw, 8'h55);
        run_frame(4'h0, 8'h00, 1'b0, rxw, acc1);
        run_frame(4'hF, 8'h00, 1'b0, rxw, acc1);

        // error injection seen through the receive model
        run_frame(4'hB, 8'h04, 1'b0, rxw, acc1);
        check("inj1_cw", codeword_out, 8'h51);
        dec = rx_decode(rxw);
        check("inj1_dec", dec, {1'b0, 1'b1, 3'd3, 4'hB});
        run_frame(4'hB, 8'h06, 1'b0, rxw, acc1);
        check("inj2_cw", codeword_out, 8'h53);
        dec = rx_decode(rxw);
        check("inj2_dbl", dec[8:7], 2'b10);

        // random words and masks
        for (int k = 0; k < 3; k++) begin
            run_frame(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b0, rxw, acc1);
        end

        // in_valid held high: back-to-back with one idle cycle
        run_frame(4'h3, 8'h00, 1'b1, rxw, acc1);
        run_frame(4'hC, 8'h00, 1'b0, rxw, acc2);
        check("b2b_gap", acc2 - acc1, 10 * CPB + 1);

        // reset in the middle of data bit 3
        data_in  = 4'h5;
        err_mask = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4 * CPB + 2) @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("mid_rst_nodone", done_cnt, d0);
        run_frame(4'h9, 8'h00, 1'b0, rxw, acc1);
        check("post_rst_frame", rxw, ref_encode(4'h9));

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
